gs232c_first_free_alloc: RTL and testbench

- Small slot buffer of (1<<N) entries of W bits, filled in lowest-index-free-slot order.
- Producer side (writer) of a priority-select path. Its packed slot_data and slot_valid outputs drive gs232c_sel_first_field directly, on i and s respectively.
- Consumer releases slots by mask after using them. The block tracks occupancy, flush and back-pressure.

---
 rtl/gs232c_alloc_pkg.sv | 26 ++
 rtl/gs232c_first_one.sv | 24 ++
 rtl/gs232c_first_free_alloc.sv | 95 +++++++++
 tb/tb_gs232c_first_free_alloc.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/gs232c_alloc_pkg.sv
// Shared sizing helpers, slot-mask type and popcount for the first-free slot allocator.
package gs232c_alloc_pkg;

  localparam int MAX_N     = 2;
  localparam int MAX_SLOTS = 1 << MAX_N;

  typedef logic [MAX_SLOTS-1:0] slot_mask_t;

  function automatic int slot_count(input int n);
    return 1 << n;
  endfunction

  function automatic int count_width(input int n);
    return n + 1;
  endfunction

  function automatic logic [MAX_N:0] popcount(input slot_mask_t v);
    logic [MAX_N:0] c;
    c = {(MAX_N+1){1'b0}};
    for (int i = 0; i < MAX_SLOTS; i++) begin
      c = c + {{MAX_N{1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/gs232c_first_one.sv
// Pure combinational lowest-set-bit selector: one-hot output, all-zero when no bit is set.
module gs232c_first_one #(
  parameter int n = 2
) (
  input  logic [(1<<n)-1:0] vec,
  output logic [(1<<n)-1:0] onehot
);

  // Scan from bit 0 upward and keep only the first hit.
  always_comb begin
    logic found_s;
    onehot  = {(1<<n){1'b0}};
    found_s = 1'b0;
    for (int i = 0; i < (1<<n); i++) begin
      if (vec[i] && !found_s) begin
        onehot[i] = 1'b1;
        found_s   = 1'b1;
      end else begin
        onehot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/gs232c_first_free_alloc.sv
// Slot buffer filled in lowest-free-index order, released by mask, with flush.
// Optional GS232C_ALLOC_RELFREE_EN lets a slot released this cycle be re-allocated this cycle.
module gs232c_first_free_alloc
  import gs232c_alloc_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  output logic [(1<<N)-1:0]  in_slot,
  input  logic [(1<<N)-1:0]  rel_mask,
  input  logic               flush,
  output logic [(1<<N)-1:0]  slot_valid,
  output logic [(W<<N)-1:0]  slot_data,
  output logic [N:0]         count
);

  localparam int S  = slot_count(N);
  localparam int CW = count_width(N);

  logic [S-1:0]  valid_r;
  logic [S-1:0]  valid_next_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic [CW-1:0] rel_cnt_s;
  logic [S-1:0]  free_s;
  logic [S-1:0]  pick_s;
  logic          accept_s;
  logic [W-1:0]  data_r [S];

`ifdef GS232C_ALLOC_RELFREE_EN
  assign free_s = ~valid_r | (rel_mask & {S{~flush}});
`else
  assign free_s = ~valid_r;
`endif

  gs232c_first_one #(.n(N)) u_first_one (
    .vec    (free_s),
    .onehot (pick_s)
  );

  // Reset is folded in so nothing is offered while the buffer is held in reset.
  assign in_slot  = pick_s & {S{~flush & resetn}};
  assign in_ready = |in_slot;
  assign accept_s = in_valid & in_ready;
  assign rel_cnt_s = CW'(popcount(slot_mask_t'(rel_mask & valid_r)));

  // Next valid vector and occupancy; allocation is applied after release so it wins on overlap.
  always_comb begin
    valid_next_s = valid_r;
    count_next_s = count_r;
    if (flush) begin
      valid_next_s = {S{1'b0}};
      count_next_s = {CW{1'b0}};
    end else begin
      valid_next_s = (valid_r & ~rel_mask) | (accept_s ? in_slot : {S{1'b0}});
      count_next_s = count_r + CW'(accept_s) - rel_cnt_s;
    end
  end

  // Occupancy state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_r <= {S{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      valid_r <= valid_next_s;
      count_r <= count_next_s;
    end
  end

  // Slot storage; released slots keep their contents.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < S; k++) data_r[k] <= {W{1'b0}};
    end else begin
      for (int k = 0; k < S; k++) begin
        if (accept_s && in_slot[k]) data_r[k] <= in_data;
        else                        data_r[k] <= data_r[k];
      end
    end
  end

  for (genvar g = 0; g < S; g++) begin : g_pack
    assign slot_data[g*W +: W] = data_r[g];
  end

  assign slot_valid = valid_r;
  assign count      = count_r;

endmodule

// File: tb/tb_gs232c_first_free_alloc.sv
// Directed self-checking bench for gs232c_first_free_alloc (default build, N=2, W=32).
module tb_gs232c_first_free_alloc;

  logic         clk;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [3:0]   in_slot;
  logic [3:0]   rel_mask;
  logic         flush;
  logic [3:0]   slot_valid;
  logic [127:0] slot_data;
  logic [2:0]   count;

  int total = 0;
  int bad   = 0;

  gs232c_first_free_alloc #(.N(2), .W(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_slot    (in_slot),
    .rel_mask   (rel_mask),
    .flush      (flush),
    .slot_valid (slot_valid),
    .slot_data  (slot_data),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_data  = 32'h0;
    rel_mask = 4'b0000;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    tick();
    tick();
    total++; if (slot_valid !== 4'b0000) begin bad++; $display("FAIL reset_valid got=%b exp=%b", slot_valid, 4'b0000); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=%0d", count, 0); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=%b", in_ready, 1'b0); end
    total++; if (in_slot !== 4'b0000) begin bad++; $display("FAIL reset_slot got=%b exp=%b", in_slot, 4'b0000); end
    total++; if (slot_data !== 128'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", slot_data); end
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_fill();
    logic [3:0] exp_slot;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + 32'(i);
      exp_slot = 4'b0001 << i;
      #1;
      total++; if (in_slot !== exp_slot) begin bad++; $display("FAIL fill_slot%0d got=%b exp=%b", i, in_slot, exp_slot); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready%0d got=%b exp=1", i, in_ready); end
      tick();
    end
    idle_inputs();
    #1;
    total++; if (slot_valid !== 4'b1111) begin bad++; $display("FAIL fill_valid got=%b exp=1111", slot_valid); end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", in_ready); end
    total++; if (in_slot !== 4'b0000) begin bad++; $display("FAIL full_slot got=%b exp=0000", in_slot); end
    total++; if (slot_data !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin bad++; $display("FAIL fill_data got=%h", slot_data); end
  endtask

  task automatic test_release_bubble();
    rel_mask = 4'b0010;
    in_valid = 1'b1;
    in_data  = 32'hB1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bubble_ready_t got=%b exp=0", in_ready); end
    tick();
    rel_mask = 4'b0000;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bubble_ready_t1 got=%b exp=1", in_ready); end
    total++; if (in_slot !== 4'b0010) begin bad++; $display("FAIL bubble_slot got=%b exp=0010", in_slot); end
    total++; if (count !== 3'd3) begin bad++; $display("FAIL bubble_count_mid got=%0d exp=3", count); end
    tick();
    idle_inputs();
    #1;
    total++; if (slot_valid !== 4'b1111) begin bad++; $display("FAIL bubble_valid got=%b exp=1111", slot_valid); end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL bubble_count got=%0d exp=4", count); end
    total++; if (slot_data[63:32] !== 32'hB1) begin bad++; $display("FAIL bubble_data got=%h exp=b1", slot_data[63:32]); end
  endtask

  task automatic test_alloc_with_release();
    rel_mask = 4'b1010;
    tick();
    rel_mask = 4'b0000;
    #1;
    total++; if (slot_valid !== 4'b0101) begin bad++; $display("FAIL relpair_valid got=%b exp=0101", slot_valid); end
    total++; if (count !== 3'd2) begin bad++; $display("FAIL relpair_count got=%0d exp=2", count); end
    in_valid = 1'b1;
    in_data  = 32'hC1;
    rel_mask = 4'b0001;
    #1;
    total++; if (in_slot !== 4'b0010) begin bad++; $display("FAIL simul_slot got=%b exp=0010", in_slot); end
    tick();
    idle_inputs();
    #1;
    total++; if (slot_valid !== 4'b0110) begin bad++; $display("FAIL simul_valid got=%b exp=0110", slot_valid); end
    total++; if (count !== 3'd2) begin bad++; $display("FAIL simul_count got=%0d exp=2", count); end
    total++; if (slot_data[63:32] !== 32'hC1) begin bad++; $display("FAIL simul_data got=%h exp=c1", slot_data[63:32]); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1;
    in_data  = 32'hE0;
    tick();
    in_data = 32'hE1;
    flush   = 1'b1;
    #1;
    total++; if (slot_valid !== 4'b0111) begin bad++; $display("FAIL preflush_valid got=%b exp=0111", slot_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
    total++; if (in_slot !== 4'b0000) begin bad++; $display("FAIL flush_slot got=%b exp=0000", in_slot); end
    tick();
    idle_inputs();
    #1;
    total++; if (slot_valid !== 4'b0000) begin bad++; $display("FAIL flush_valid got=%b exp=0000", slot_valid); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
  endtask

  task automatic test_invalid_release();
    in_valid = 1'b1;
    in_data  = 32'hD0;
    tick();
    idle_inputs();
    rel_mask = 4'b1000;
    tick();
    rel_mask = 4'b0000;
    #1;
    total++; if (slot_valid !== 4'b0001) begin bad++; $display("FAIL badrel_valid got=%b exp=0001", slot_valid); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL badrel_count got=%0d exp=1", count); end
    total++; if (slot_data[31:0] !== 32'hD0) begin bad++; $display("FAIL badrel_data got=%h exp=d0", slot_data[31:0]); end
  endtask

  task automatic test_reset_mid_burst();
    in_valid = 1'b1;
    in_data  = 32'hF0;
    tick();
    in_data = 32'hF1;
    #2;
    resetn = 1'b0;
    #1;
    total++; if (slot_valid !== 4'b0000) begin bad++; $display("FAIL midrst_valid got=%b exp=0000", slot_valid); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", in_ready); end
    total++; if (slot_data !== 128'h0) begin bad++; $display("FAIL midrst_data got=%h exp=0", slot_data); end
    tick();
    resetn  = 1'b1;
    in_data = 32'hF2;
    #1;
    total++; if (in_slot !== 4'b0001) begin bad++; $display("FAIL postrst_slot got=%b exp=0001", in_slot); end
    tick();
    idle_inputs();
    #1;
    total++; if (slot_valid !== 4'b0001) begin bad++; $display("FAIL postrst_valid got=%b exp=0001", slot_valid); end
    total++; if (slot_data[31:0] !== 32'hF2) begin bad++; $display("FAIL postrst_data got=%h exp=f2", slot_data[31:0]); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_release_bubble();
    test_alloc_with_release();
    test_flush();
    test_invalid_release();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
